wave_sweep_ctrl: RTL

- Sequencer that drives the frequency control word and waveform select of the DDS wave generator.
- Two operating regimes:
  - Manual pass-through: waveform select follows the switches.
  - Automatic sweep: the frequency word steps between a start and a stop value, holding each value for a programmable dwell. The waveform can optionally advance after every completed sweep.
- Sits between the board switches/buttons and the wave generator's freq_ctrl/sw inputs, in the clk_100kHz domain.

---
 rtl/wave_sweep_ctrl_pkg.sv | 28 ++
 rtl/wave_sweep_ctrl_if.sv | 32 +++
 rtl/wave_sweep_ctrl_dwell_timer.sv | 26 ++
 rtl/wave_sweep_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/wave_sweep_ctrl_pkg.sv
// Shared types for the DDS sweep sequencer: FSM states, sweep modes and
// waveform select codes of the wave generator.
package wave_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    typedef enum logic {
        MODE_RAMP = 1'b0,
        MODE_TRI  = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        SINE   = 2'd0,
        TRI    = 2'd1,
        SQUARE = 2'd2,
        SAW    = 2'd3
    } wave_t;

    // Waveform order after a completed sweep; SAW wraps back to SINE.
    function automatic logic [1:0] next_wave(input logic [1:0] w);
        return (w == SAW) ? SINE : (w + 2'd1);
    endfunction

endpackage

// File: rtl/wave_sweep_ctrl_if.sv
// Control/status bundle between the switch/button front end and the sweep
// sequencer; the sequencer side uses the slave modport.
interface wave_sweep_ctrl_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic               sweep_mode;
    logic               auto_wave;
    logic [1:0]         wave_sel_in;
    logic [7:0]         f_start;
    logic [7:0]         f_stop;
    logic [7:0]         f_step;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         freq_ctrl;
    logic [1:0]         sw;
    logic               busy;
    logic               sweep_done;
    logic               cfg_err;

    modport master (
        output start, stop, sweep_mode, auto_wave, wave_sel_in,
               f_start, f_stop, f_step, dwell,
        input  freq_ctrl, sw, busy, sweep_done, cfg_err
    );

    modport slave (
        input  start, stop, sweep_mode, auto_wave, wave_sel_in,
               f_start, f_stop, f_step, dwell,
        output freq_ctrl, sw, busy, sweep_done, cfg_err
    );
endinterface

// File: rtl/wave_sweep_ctrl_dwell_timer.sv
// Dwell timer: counts 0..dwell_l while running and flags the step event in
// the cycle the count reaches dwell_l, so each frequency is held dwell_l+1 cycles.
module dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk_100kHz,
    input  logic               rst_,
    input  logic               clear,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell_l,
    output logic               step_evt
);
    logic [DWELL_W-1:0] dwell_cnt;

    assign step_evt = run && (dwell_cnt == dwell_l);

    always_ff @(posedge clk_100kHz or posedge rst_) begin
        if (rst_) begin
            dwell_cnt <= '0;
        end else if (clear) begin
            dwell_cnt <= '0;
        end else if (run) begin
            dwell_cnt <= step_evt ? '0 : (dwell_cnt + 1'b1);
        end
    end
endmodule

// File: rtl/wave_sweep_ctrl.sv
// Sweep sequencer for the DDS wave generator: manual waveform pass-through in
// IDLE, ramp or triangle frequency sweep with per-step dwell when running.
module wave_sweep_ctrl
    import wave_ctrl_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic        clk_100kHz,
    input  logic        rst_,
    wave_sweep_ctrl_if.slave bus
);
    // state   | meaning
    // --------+-------------------------------------------------------------
    // ST_IDLE | sw follows wave_sel_in, freq_ctrl frozen, waiting for start
    // ST_UP   | stepping freq_ctrl up from f_start_l towards f_stop_l
    // ST_DOWN | triangle mode only: stepping back down towards f_start_l

    state_t             state;
    mode_t              mode_l;
    logic               auto_wave_l;
    logic [7:0]         f_start_l;
    logic [7:0]         f_stop_l;
    logic [7:0]         f_step_l;
    logic [DWELL_W-1:0] dwell_l;

    logic [7:0]         freq_q;
    logic [1:0]         sw_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               cfg_ok;
    logic               accept;
    logic               step_evt;
    logic [8:0]         next_up;
    logic [8:0]         next_dn;
    logic [1:0]         sw_adv;

    assign cfg_ok  = (bus.f_start <= bus.f_stop) && (bus.f_step != 8'd0);
    assign accept  = bus.start && !bus.stop && cfg_ok;
    // Ninth bit keeps the carry/borrow so an 8-bit wrap is never mistaken
    // for an in-range frequency.
    assign next_up = {1'b0, freq_q} + {1'b0, f_step_l};
    assign next_dn = {1'b0, freq_q} - {1'b0, f_step_l};
    assign sw_adv  = auto_wave_l ? next_wave(sw_q) : sw_q;

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk_100kHz (clk_100kHz),
        .rst_       (rst_),
        .clear      (accept || bus.stop),
        .run        (state != ST_IDLE),
        .dwell_l    (dwell_l),
        .step_evt   (step_evt)
    );

    always_ff @(posedge clk_100kHz or posedge rst_) begin
        if (rst_) begin
            state       <= ST_IDLE;
            mode_l      <= MODE_RAMP;
            auto_wave_l <= 1'b0;
            f_start_l   <= 8'd0;
            f_stop_l    <= 8'd0;
            f_step_l    <= 8'd0;
            dwell_l     <= '0;
            freq_q      <= 8'd0;
            sw_q        <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.stop) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end else if (accept) begin
                state       <= ST_UP;
                busy_q      <= 1'b1;
                mode_l      <= mode_t'(bus.sweep_mode);
                auto_wave_l <= bus.auto_wave;
                f_start_l   <= bus.f_start;
                f_stop_l    <= bus.f_stop;
                f_step_l    <= bus.f_step;
                dwell_l     <= bus.dwell;
                freq_q      <= bus.f_start;
                sw_q        <= bus.wave_sel_in;
            end else begin
                // A start that reaches here had a bad config; any sweep keeps running.
                err_q <= bus.start;
                case (state)
                    ST_IDLE: begin
                        sw_q   <= bus.wave_sel_in;
                        busy_q <= 1'b0;
                    end
                    ST_UP: begin
                        if (step_evt) begin
                            if (next_up <= {1'b0, f_stop_l}) begin
                                freq_q <= next_up[7:0];
                            end else if (mode_l == MODE_RAMP) begin
                                freq_q <= f_start_l;
                                done_q <= 1'b1;
                                sw_q   <= sw_adv;
                            end else begin
                                state <= ST_DOWN;
                            end
                        end
                    end
                    ST_DOWN: begin
                        if (step_evt) begin
                            if (!next_dn[8] && (next_dn[7:0] >= f_start_l)) begin
                                freq_q <= next_dn[7:0];
                            end else begin
                                freq_q <= f_start_l;
                                done_q <= 1'b1;
                                sw_q   <= sw_adv;
                                state  <= ST_UP;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.freq_ctrl  = freq_q;
    assign bus.sw         = sw_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = done_q;
    assign bus.cfg_err    = err_q;
endmodule
